l3_pt_wave_search: RTL and testbench
====================================

Name: l3_pt_wave_search

Overview:
- Downstream consumer of the level-3 DWT/QRS stage.
- Once the Q-begin and S-end markers are final, it scans the stored level-3 approximation coefficients (cA) through a read port.
- Finds the P-wave peak (before Q) and the T-wave peak (after S), and reports peak positions, peak values and QRS duration in input-sample units.
- Feeds the feature-output/formatting stage.

Parameters:
- DW, 17, coefficient width (signed cA, matches level-3 coefficient width)
- PW, 12, coefficient index/position width
- N_COEF, 100, number of valid level-3 coefficients (indices 0..N_COEF-1)
- P_WIN, 20, P search window length in coefficients
- T_WIN, 40, T search window length in coefficients
- DEC_SHIFT, 3, log2 of level-3 decimation (index to sample conversion)

Ports:
- clk  in  1  clock
- nReset  in  1  asynchronous, active-low reset
- Enable  in  1  stage enable; low acts as synchronous clear
- start  in  1  one-cycle pulse: markers valid, begin search
- q_begin  in  PW  Q onset, coefficient index
- s_end  in  PW  S end, coefficient index
- q_valid  in  1  q_begin meaningful
- s_valid  in  1  s_end meaningful
- coef_rd  out  1  read strobe
- coef_addr  out  PW  cA index requested
- coef_data  in  DW  signed cA; valid exactly 1 cycle after coef_rd
- p_pos  out  PW  P peak index
- p_val  out  DW  P peak value (signed)
- t_pos  out  PW  T peak index
- t_val  out  DW  T peak value (signed)
- qrs_dur  out  16  (s_end - q_begin) << DEC_SHIFT
- p_found  out  1  P window non-empty and searched
- t_found  out  1  T window non-empty and searched
- err  out  1  invalid markers
- busy  out  1  search in progress
- done  out  1  results valid; held until next accepted start

Behaviour:
- Reset (nReset low, or Enable low at clock edge): all outputs 0, FSM in IDLE, internal max/position registers 0.
- FSM states: IDLE, CHECK, P_SCAN, P_DRAIN, T_SCAN, T_DRAIN, DONE.
- IDLE: start=1 goes to CHECK, clears done/found/err, sets busy. start is ignored in every non-IDLE state except DONE, where start behaves as in IDLE.
- CHECK (1 cycle):
  - err condition: !q_valid | !s_valid | q_begin>=s_end | s_end>=N_COEF. If true: err=1, found flags 0, qrs_dur 0, go to DONE.
  - Otherwise latch the windows:
    - P window [max(0, q_begin-P_WIN), q_begin-1]; empty if q_begin==0.
    - T window [s_end+1, min(N_COEF-1, s_end+T_WIN)]; empty if s_end==N_COEF-1.
  - Compute qrs_dur with zero-extension before the shift.
- P_SCAN:
  - coef_rd=1; coef_addr steps lo..hi, one index per cycle.
  - The address is delayed 1 cycle and paired with the returned coef_data.
  - First returned sample initialises the max. A later sample replaces it only if strictly greater (signed), so on ties the earliest index wins.
  - After issuing hi, go to P_DRAIN: coef_rd=0, compare the last sample.
  - If the P window is empty, skip P_SCAN/P_DRAIN (0 cycles) and p_found=0.
- T_SCAN/T_DRAIN: identical procedure on the T window, result to t_pos/t_val.
- DONE: registered outputs valid, done=1, busy=0. Outputs hold until the next accepted start or a clear.
- Latency: start sampled at edge 0 gives done high after edge 4+Lp+Lt (Lp/Lt = window lengths, 0 when empty). Full windows: 64 cycles.
- coef_rd is never high outside P_SCAN/T_SCAN. coef_addr holds its last value when idle.
- Reset or Enable low mid-scan: immediate abort to IDLE with outputs 0; no partial results.
- Arithmetic:
  - Window bounds are computed in PW+1 bits so the subtraction cannot wrap negative.
  - Signed compare on DW bits.

Decomposition:
- Shared package:
  - FSM state enum
  - DW/PW widths
  - N_COEF
  - DEC_SHIFT (shared with level-3 stage)
  - P_WIN/T_WIN defaults
- One natural sub-module: l3_window_peak. It is a generic lo/hi read-and-argmax scanner with start/done, instantiated once and time-shared for the P and T windows.

Test Plan:
- q_begin=40, s_end=50, cA[25]=300 peak in 20..39, cA[70]=500 peak in 51..90, others 0 -> p_pos=25, p_val=300, t_pos=70, t_val=500, qrs_dur=80, p_found=t_found=1, done high after 64 cycles.
- q_begin=5, s_end=95 -> P window 0..4 and T window 96..99; exactly 5 and 4 reads issued; done after 13 cycles; qrs_dur=720.
- q_begin=0, s_end=99 -> p_found=0, t_found=0, no coef_rd pulses, done after 4 cycles, err=0.
- q_begin=60, s_end=60 (also q_valid=0 separately) -> err=1, found=0, qrs_dur=0, no reads.
- Tie and negative values: P window all -10, with -3 at indices 22 and 30 -> p_pos=22, p_val=-3.
- Enable dropped at cycle 10 of P_SCAN, then restored with a new start -> outputs 0 immediately; second run gives correct results; start pulsed mid-scan is ignored.

Source files
------------

// File: rtl/l3_pt_wave_search_pkg.sv
// Shared widths, limits and FSM encoding for the level-3 P/T wave search.
package l3_pt_wave_search_pkg;

    localparam int L3_DW        = 17;   // signed cA width
    localparam int L3_PW        = 12;   // coefficient index width
    localparam int L3_N_COEF    = 100;  // valid coefficients 0..N_COEF-1
    localparam int L3_P_WIN     = 20;   // P search window length
    localparam int L3_T_WIN     = 40;   // T search window length
    localparam int L3_DEC_SHIFT = 3;    // log2 of level-3 decimation

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_P_SCAN,
        ST_P_DRAIN,
        ST_T_SCAN,
        ST_T_DRAIN,
        ST_DONE
    } l3_state_e;

endpackage

// File: rtl/l3_pt_wave_search_window_peak.sv
// Generic lo..hi read-and-argmax scanner; one read per cycle, data returns
// one cycle later and is compared against the running signed maximum.
module l3_window_peak
    import l3_pt_wave_search_pkg::*;
#(
    parameter int DW = L3_DW,
    parameter int PW = L3_PW
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 clr,
    input  logic                 start,
    input  logic [PW-1:0]        lo,
    input  logic [PW-1:0]        hi,
    output logic                 coef_rd,
    output logic [PW-1:0]        coef_addr,
    input  logic signed [DW-1:0] coef_data,
    output logic                 last_issue,
    output logic                 done,
    output logic [PW-1:0]        peak_pos,
    output logic signed [DW-1:0] peak_val
);

    logic [PW-1:0]        addr_q, addr_d;
    logic [PW-1:0]        hi_q, hi_d;
    logic [PW-1:0]        paddr_q, paddr_d;
    logic                 act_q, act_d;
    logic                 vld_q, vld_d;
    logic                 first_q, first_d;
    logic [PW-1:0]        max_pos_q, max_pos_d;
    logic signed [DW-1:0] max_val_q, max_val_d;

    // Address sequencing, read-return alignment and running argmax.
    always_comb begin
        addr_d    = addr_q;
        hi_d      = hi_q;
        act_d     = act_q;
        vld_d     = act_q;
        paddr_d   = addr_q;
        first_d   = first_q;
        max_pos_d = max_pos_q;
        max_val_d = max_val_q;

        // Strictly-greater replace keeps the earliest index on ties.
        if (vld_q) begin
            if (first_q || (coef_data > max_val_q)) begin
                max_val_d = coef_data;
                max_pos_d = paddr_q;
                first_d   = 1'b0;
            end
        end

        if (act_q) begin
            if (addr_q == hi_q) act_d = 1'b0;
            else                addr_d = addr_q + PW'(1);
        end

        if (start) begin
            addr_d  = lo;
            hi_d    = hi;
            act_d   = 1'b1;
            first_d = 1'b1;
        end

        if (clr) begin
            addr_d    = '0;
            hi_d      = '0;
            act_d     = 1'b0;
            vld_d     = 1'b0;
            paddr_d   = '0;
            first_d   = 1'b0;
            max_pos_d = '0;
            max_val_d = '0;
        end
    end

    // Scanner state registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            addr_q    <= '0;
            hi_q      <= '0;
            act_q     <= 1'b0;
            vld_q     <= 1'b0;
            paddr_q   <= '0;
            first_q   <= 1'b0;
            max_pos_q <= '0;
            max_val_q <= '0;
        end else begin
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            act_q     <= act_d;
            vld_q     <= vld_d;
            paddr_q   <= paddr_d;
            first_q   <= first_d;
            max_pos_q <= max_pos_d;
            max_val_q <= max_val_d;
        end
    end

    assign coef_rd    = act_q;
    assign coef_addr  = addr_q;
    assign last_issue = act_q && (addr_q == hi_q);
    assign done       = vld_q && !act_q;
    // Post-compare values so the final sample is included in the drain cycle.
    assign peak_pos   = max_pos_d;
    assign peak_val   = max_val_d;

endmodule

// File: rtl/l3_pt_wave_search.sv
// P/T wave peak search over stored level-3 cA once QRS markers are final.
module l3_pt_wave_search
    import l3_pt_wave_search_pkg::*;
#(
    parameter int DW        = L3_DW,
    parameter int PW        = L3_PW,
    parameter int N_COEF    = L3_N_COEF,
    parameter int P_WIN     = L3_P_WIN,
    parameter int T_WIN     = L3_T_WIN,
    parameter int DEC_SHIFT = L3_DEC_SHIFT
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 Enable,
    input  logic                 start,
    input  logic [PW-1:0]        q_begin,
    input  logic [PW-1:0]        s_end,
    input  logic                 q_valid,
    input  logic                 s_valid,
    output logic                 coef_rd,
    output logic [PW-1:0]        coef_addr,
    input  logic signed [DW-1:0] coef_data,
    output logic [PW-1:0]        p_pos,
    output logic signed [DW-1:0] p_val,
    output logic [PW-1:0]        t_pos,
    output logic signed [DW-1:0] t_val,
    output logic [15:0]          qrs_dur,
    output logic                 p_found,
    output logic                 t_found,
    output logic                 err,
    output logic                 busy,
    output logic                 done
);

    localparam logic [PW:0]   P_WIN_X  = (PW+1)'(P_WIN);
    localparam logic [PW:0]   T_WIN_X  = (PW+1)'(T_WIN);
    localparam logic [PW:0]   NC_M1_X  = (PW+1)'(N_COEF - 1);
    localparam logic [PW-1:0] NC_P     = PW'(N_COEF);
    localparam logic [PW-1:0] NC_M1_P  = PW'(N_COEF - 1);

    l3_state_e state_q, state_d;

    logic                 p_ne_q, p_ne_d;
    logic                 t_ne_q, t_ne_d;
    logic [PW-1:0]        t_lo_q, t_lo_d;
    logic [PW-1:0]        t_hi_q, t_hi_d;
    logic [PW-1:0]        p_pos_q, p_pos_d;
    logic signed [DW-1:0] p_val_q, p_val_d;
    logic [PW-1:0]        t_pos_q, t_pos_d;
    logic signed [DW-1:0] t_val_q, t_val_d;
    logic [15:0]          qrs_q, qrs_d;
    logic                 p_found_q, p_found_d;
    logic                 t_found_q, t_found_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 err_c, p_ne_c, t_ne_c;
    logic [PW:0]          qb_x, t_sum_x;
    logic [PW-1:0]        p_lo_c, p_hi_c, t_lo_c, t_hi_c, span_c;
    logic [15:0]          qrs_c;

    logic                 scan_start, scan_last, scan_done;
    logic [PW-1:0]        scan_lo, scan_hi, scan_pos;
    logic signed [DW-1:0] scan_val;

    // Marker validation and window bounds, widened so subtraction cannot wrap.
    always_comb begin
        qb_x    = {1'b0, q_begin};
        t_sum_x = {1'b0, s_end} + T_WIN_X;
        err_c   = !q_valid || !s_valid || (q_begin >= s_end) || (s_end >= NC_P);
        p_ne_c  = (q_begin != '0);
        t_ne_c  = (s_end != NC_M1_P);
        p_lo_c  = (qb_x >= P_WIN_X) ? PW'(qb_x - P_WIN_X) : '0;
        p_hi_c  = q_begin - PW'(1);
        t_lo_c  = s_end + PW'(1);
        t_hi_c  = (t_sum_x > NC_M1_X) ? NC_M1_P : PW'(t_sum_x);
        span_c  = s_end - q_begin;
        qrs_c   = 16'(span_c) << DEC_SHIFT;
    end

    // Sequencing of check, P scan, T scan and result capture.
    always_comb begin
        state_d    = state_q;
        p_ne_d     = p_ne_q;
        t_ne_d     = t_ne_q;
        t_lo_d     = t_lo_q;
        t_hi_d     = t_hi_q;
        p_pos_d    = p_pos_q;
        p_val_d    = p_val_q;
        t_pos_d    = t_pos_q;
        t_val_d    = t_val_q;
        qrs_d      = qrs_q;
        p_found_d  = p_found_q;
        t_found_d  = t_found_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = done_q;
        scan_start = 1'b0;
        scan_lo    = p_lo_c;
        scan_hi    = p_hi_c;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_CHECK;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    p_found_d = 1'b0;
                    t_found_d = 1'b0;
                    p_pos_d   = '0;
                    p_val_d   = '0;
                    t_pos_d   = '0;
                    t_val_d   = '0;
                    qrs_d     = '0;
                end else if (state_q == ST_DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (err_c) begin
                    err_d   = 1'b1;
                    qrs_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    qrs_d   = qrs_c;
                    p_ne_d  = p_ne_c;
                    t_ne_d  = t_ne_c;
                    t_lo_d  = t_lo_c;
                    t_hi_d  = t_hi_c;
                    // An empty window still spends its drain cycle, keeping
                    // total latency at 4 + Lp + Lt for every marker pair.
                    if (p_ne_c) begin
                        scan_start = 1'b1;
                        state_d    = ST_P_SCAN;
                    end else begin
                        state_d    = ST_P_DRAIN;
                    end
                end
            end
            ST_P_SCAN: begin
                if (scan_last) state_d = ST_P_DRAIN;
            end
            ST_P_DRAIN: begin
                if (p_ne_q && scan_done) begin
                    p_found_d = 1'b1;
                    p_pos_d   = scan_pos;
                    p_val_d   = scan_val;
                end
                scan_lo = t_lo_q;
                scan_hi = t_hi_q;
                if (t_ne_q) begin
                    scan_start = 1'b1;
                    state_d    = ST_T_SCAN;
                end else begin
                    state_d    = ST_T_DRAIN;
                end
            end
            ST_T_SCAN: begin
                if (scan_last) state_d = ST_T_DRAIN;
            end
            ST_T_DRAIN: begin
                if (t_ne_q && scan_done) begin
                    t_found_d = 1'b1;
                    t_pos_d   = scan_pos;
                    t_val_d   = scan_val;
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!Enable) begin
            state_d    = ST_IDLE;
            p_ne_d     = 1'b0;
            t_ne_d     = 1'b0;
            t_lo_d     = '0;
            t_hi_d     = '0;
            p_pos_d    = '0;
            p_val_d    = '0;
            t_pos_d    = '0;
            t_val_d    = '0;
            qrs_d      = '0;
            p_found_d  = 1'b0;
            t_found_d  = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            scan_start = 1'b0;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            p_ne_q    <= 1'b0;
            t_ne_q    <= 1'b0;
            t_lo_q    <= '0;
            t_hi_q    <= '0;
            p_pos_q   <= '0;
            p_val_q   <= '0;
            t_pos_q   <= '0;
            t_val_q   <= '0;
            qrs_q     <= '0;
            p_found_q <= 1'b0;
            t_found_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_ne_q    <= p_ne_d;
            t_ne_q    <= t_ne_d;
            t_lo_q    <= t_lo_d;
            t_hi_q    <= t_hi_d;
            p_pos_q   <= p_pos_d;
            p_val_q   <= p_val_d;
            t_pos_q   <= t_pos_d;
            t_val_q   <= t_val_d;
            qrs_q     <= qrs_d;
            p_found_q <= p_found_d;
            t_found_q <= t_found_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    l3_window_peak #(
        .DW (DW),
        .PW (PW)
    ) u_peak (
        .clk        (clk),
        .nReset     (nReset),
        .clr        (!Enable),
        .start      (scan_start),
        .lo         (scan_lo),
        .hi         (scan_hi),
        .coef_rd    (coef_rd),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .last_issue (scan_last),
        .done       (scan_done),
        .peak_pos   (scan_pos),
        .peak_val   (scan_val)
    );

    assign p_pos   = p_pos_q;
    assign p_val   = p_val_q;
    assign t_pos   = t_pos_q;
    assign t_val   = t_val_q;
    assign qrs_dur = qrs_q;
    assign p_found = p_found_q;
    assign t_found = t_found_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_l3_pt_wave_search.sv
// Scoreboard bench for l3_pt_wave_search with a behavioural cA memory.
module tb_l3_pt_wave_search;

    localparam int DW = 17;
    localparam int PW = 12;
    localparam int NC = 100;

    logic                 clk = 1'b0;
    logic                 nReset = 1'b0;
    logic                 Enable = 1'b1;
    logic                 start = 1'b0;
    logic [PW-1:0]        q_begin = '0;
    logic [PW-1:0]        s_end = '0;
    logic                 q_valid = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 coef_rd;
    logic [PW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_data = '0;
    logic [PW-1:0]        p_pos, t_pos;
    logic signed [DW-1:0] p_val, t_val;
    logic [15:0]          qrs_dur;
    logic                 p_found, t_found, err, busy, done;

    logic signed [DW-1:0] mem [0:NC-1];

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit                   err;
        bit                   pf;
        bit                   tf;
        logic [PW-1:0]        pp;
        logic [PW-1:0]        tp;
        logic signed [DW-1:0] pv;
        logic signed [DW-1:0] tv;
        logic [15:0]          qrs;
        int                   reads;
        int                   lat;
        int                   plo, phi, tlo, thi;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    l3_pt_wave_search dut (
        .clk       (clk),
        .nReset    (nReset),
        .Enable    (Enable),
        .start     (start),
        .q_begin   (q_begin),
        .s_end     (s_end),
        .q_valid   (q_valid),
        .s_valid   (s_valid),
        .coef_rd   (coef_rd),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .p_pos     (p_pos),
        .p_val     (p_val),
        .t_pos     (t_pos),
        .t_val     (t_val),
        .qrs_dur   (qrs_dur),
        .p_found   (p_found),
        .t_found   (t_found),
        .err       (err),
        .busy      (busy),
        .done      (done)
    );

    // Read port: data for an address appears one cycle after the strobe.
    always @(posedge clk) begin
        if (coef_rd && (coef_addr < PW'(NC))) coef_data <= mem[coef_addr];
        else                                  coef_data <= 17'sh15555;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int qb, input int sb, input bit qv, input bit sv);
        exp_t e;
        e.err = 0; e.pf = 0; e.tf = 0;
        e.pp = '0; e.tp = '0; e.pv = '0; e.tv = '0; e.qrs = '0;
        e.plo = 1; e.phi = 0; e.tlo = 1; e.thi = 0;
        if (!qv || !sv || qb >= sb || sb >= NC) begin
            e.err = 1;
        end else begin
            e.qrs = 16'((sb - qb) * 8);
            if (qb > 0) begin
                e.pf  = 1;
                e.plo = (qb >= 20) ? qb - 20 : 0;
                e.phi = qb - 1;
                e.pv  = mem[e.plo];
                e.pp  = PW'(e.plo);
                for (int i = e.plo + 1; i <= e.phi; i++)
                    if (mem[i] > e.pv) begin e.pv = mem[i]; e.pp = PW'(i); end
            end
            if (sb < NC - 1) begin
                e.tf  = 1;
                e.tlo = sb + 1;
                e.thi = (sb + 40 > NC - 1) ? NC - 1 : sb + 40;
                e.tv  = mem[e.tlo];
                e.tp  = PW'(e.tlo);
                for (int i = e.tlo + 1; i <= e.thi; i++)
                    if (mem[i] > e.tv) begin e.tv = mem[i]; e.tp = PW'(i); end
            end
        end
        e.reads = (e.phi - e.plo + 1) + (e.thi - e.tlo + 1);
        e.lat   = 4 + e.reads;
        return e;
    endfunction

    task automatic run_case(input int qb, input int sb, input bit qv, input bit sv, input int glitch_at);
        exp_t w;
        exp_t e;
        int lat, reads, bad, a;
        @(negedge clk);
        q_begin = PW'(qb); s_end = PW'(sb); q_valid = qv; s_valid = sv;
        start = 1'b1;
        sb_q.push_back(model(qb, sb, qv, sv));
        w = sb_q[0];
        @(posedge clk);
        lat = 0; reads = 0; bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == glitch_at);
            if (k == glitch_at) begin q_begin = PW'(5); s_end = PW'(95); end
            @(posedge clk);
            #1;
            if (coef_rd) begin
                reads++;
                a = int'(coef_addr);
                if (!((a >= w.plo && a <= w.phi) || (a >= w.tlo && a <= w.thi))) bad++;
            end
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        chk("done_seen", 32'(done), 32'd1);
        if (!e.err) chk("latency", 32'(lat), 32'(e.lat));
        chk("err", 32'(err), 32'(e.err));
        chk("p_found", 32'(p_found), 32'(e.pf));
        chk("t_found", 32'(t_found), 32'(e.tf));
        chk("qrs_dur", 32'(qrs_dur), 32'(e.qrs));
        chk("reads", 32'(reads), 32'(e.reads));
        chk("bad_addr", 32'(bad), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        if (e.pf) begin
            chk("p_pos", 32'(p_pos), 32'(e.pp));
            chk("p_val", 32'(p_val), 32'(e.pv));
        end
        if (e.tf) begin
            chk("t_pos", 32'(t_pos), 32'(e.tp));
            chk("t_val", 32'(t_val), 32'(e.tv));
        end
    endtask

    task automatic fill_zero_peaks();
        for (int i = 0; i < NC; i++) mem[i] = '0;
        mem[25] = 17'sd300;
        mem[70] = 17'sd500;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(coef_rd), 32'd0);
        chk("rst_addr", 32'(coef_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_qrs", 32'(qrs_dur), 32'd0);
        chk("rst_pf", 32'(p_found), 32'd0);
        @(negedge clk);
        nReset = 1'b1;

        // Isolated peaks in both windows, full-length windows.
        fill_zero_peaks();
        run_case(40, 50, 1, 1, 0);

        // Clipped windows with random signed data.
        for (int i = 0; i < NC; i++) mem[i] = DW'($urandom_range(0, 2000)) - 17'sd1000;
        run_case(5, 95, 1, 1, 0);
        run_case(70, 98, 1, 1, 0);

        // Both windows empty.
        run_case(0, 99, 1, 1, 0);

        // Invalid markers.
        run_case(60, 60, 1, 1, 0);
        run_case(40, 50, 0, 1, 0);
        run_case(10, 100, 1, 1, 0);

        // Ties and negative values in the P window.
        for (int i = 0; i < NC; i++) mem[i] = -17'sd10;
        mem[22] = -17'sd3;
        mem[30] = -17'sd3;
        run_case(40, 50, 1, 1, 0);
        chk("tie_p_pos", 32'(p_pos), 32'd22);

        // Abort mid P scan, then a clean run with a stray start mid-scan.
        fill_zero_peaks();
        @(negedge clk);
        q_begin = PW'(40); s_end = PW'(50); q_valid = 1'b1; s_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_rd", 32'(coef_rd), 32'd1);
        @(negedge clk);
        Enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd", 32'(coef_rd), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_qrs", 32'(qrs_dur), 32'd0);
        @(negedge clk);
        Enable = 1'b1;
        run_case(40, 50, 1, 1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
